// File: rtl/binario_para_display.sv
// rtl/binario_para_display.sv - sequential binary-to-BCD encoder (double-dabble) for a two-digit display
module binario_para_display #(
    parameter int LARGURA    = 8,
    parameter bit COM_SINAL  = 1'b1,
    parameter bit APAGA_ZERO = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [LARGURA-1:0] valor,
    output logic               ocupado,
    output logic               concluido,
    output logic               sinal,
    output logic [3:0]         dezena,
    output logic [3:0]         unidade
);

    localparam int CW = $clog2(LARGURA + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        FINALIZA
    } estado_t;

    estado_t            estado;
    logic               neg;
    logic [LARGURA-1:0] mag;
    logic [19:0]        bcd;
    logic [CW-1:0]      contador;
    logic [15:0]        bcd_adj;
    logic               neg_entrada;

    assign neg_entrada = COM_SINAL & valor[LARGURA-1];

    // Only the four low digits need the add-3 step: for at most 16 input bits the
    // fifth digit never reaches 5 before its final shift.
    always_comb begin
        bcd_adj = bcd[15:0];
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            ocupado   <= 1'b0;
            concluido <= 1'b0;
            sinal     <= 1'b0;
            dezena    <= 4'hA;
            unidade   <= 4'hA;
            neg       <= 1'b0;
            mag       <= '0;
            bcd       <= '0;
            contador  <= '0;
        end else begin
            concluido <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        neg      <= neg_entrada;
                        mag      <= neg_entrada ? (~valor + LARGURA'(1)) : valor;
                        bcd      <= '0;
                        contador <= '0;
                        ocupado  <= 1'b1;
                        estado   <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    bcd      <= {bcd[18:16], bcd_adj, mag[LARGURA-1]};
                    mag      <= mag << 1;
                    contador <= contador + 1'b1;
                    if (contador == ULTIMO) begin
                        estado <= FINALIZA;
                    end
                end
                FINALIZA: begin
                    ocupado   <= 1'b0;
                    concluido <= 1'b1;
                    estado    <= OCIOSO;
                    if (|bcd[19:8]) begin
                        sinal   <= 1'b0;
                        dezena  <= 4'hF;
                        unidade <= 4'hF;
                    end else begin
                        sinal   <= neg;
                        unidade <= bcd[3:0];
                        dezena  <= (bcd[7:4] == 4'd0 && APAGA_ZERO) ? 4'hA : bcd[7:4];
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binario_para_display.sv
// tb/tb_binario_para_display.sv - directed bench for binario_para_display across four parameter sets
module tb_binario_para_display;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iniciar [4];
    logic [15:0] valor   [4];
    logic        ocup    [4];
    logic        conc    [4];
    logic        sin     [4];
    logic [3:0]  dez     [4];
    logic [3:0]  uni     [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // u0: defaults, u1: tens zero shown as 0, u2: unsigned, u3: 4-bit signed
    binario_para_display u0 (
        .clock(clock), .reset(reset), .iniciar(iniciar[0]), .valor(valor[0][7:0]),
        .ocupado(ocup[0]), .concluido(conc[0]), .sinal(sin[0]), .dezena(dez[0]), .unidade(uni[0]));
    binario_para_display #(.APAGA_ZERO(1'b0)) u1 (
        .clock(clock), .reset(reset), .iniciar(iniciar[1]), .valor(valor[1][7:0]),
        .ocupado(ocup[1]), .concluido(conc[1]), .sinal(sin[1]), .dezena(dez[1]), .unidade(uni[1]));
    binario_para_display #(.COM_SINAL(1'b0)) u2 (
        .clock(clock), .reset(reset), .iniciar(iniciar[2]), .valor(valor[2][7:0]),
        .ocupado(ocup[2]), .concluido(conc[2]), .sinal(sin[2]), .dezena(dez[2]), .unidade(uni[2]));
    binario_para_display #(.LARGURA(4)) u3 (
        .clock(clock), .reset(reset), .iniciar(iniciar[3]), .valor(valor[3][3:0]),
        .ocupado(ocup[3]), .concluido(conc[3]), .sinal(sin[3]), .dezena(dez[3]), .unidade(uni[3]));

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns number of rising edges after the start edge until concluido is seen, -1 on timeout.
    task automatic wait_done(input int idx, output int n);
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (conc[idx]) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic run(input int idx, input logic [15:0] v, input string tag,
                       input int es, input int ed, input int eu);
        int n;
        int lat;
        lat = (idx == 3) ? 5 : 9;
        @(negedge clock);
        valor[idx]   = v;
        iniciar[idx] = 1'b1;
        @(negedge clock);
        iniciar[idx] = 1'b0;
        check({tag, ".busy"}, int'(ocup[idx]), 1);
        wait_done(idx, n);
        check({tag, ".lat"}, n, lat);
        check({tag, ".sinal"}, int'(sin[idx]), es);
        check({tag, ".dezena"}, int'(dez[idx]), ed);
        check({tag, ".unidade"}, int'(uni[idx]), eu);
        check({tag, ".idle"}, int'(ocup[idx]), 0);
        @(negedge clock);
        check({tag, ".pulse"}, int'(conc[idx]), 0);
    endtask

    initial begin
        int n;
        int pulses;
        for (int i = 0; i < 4; i++) begin
            iniciar[i] = 1'b0;
            valor[i]   = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst.ocupado", int'(ocup[0]), 0);
        check("rst.concluido", int'(conc[0]), 0);
        check("rst.sinal", int'(sin[0]), 0);
        check("rst.dezena", int'(dez[0]), 'hA);
        check("rst.unidade", int'(uni[0]), 'hA);

        run(0, 16'd42,   "d42",   0, 4,   2);
        run(0, 16'hF9,   "m7",    1, 'hA, 7);
        run(1, 16'hF9,   "m7nz",  1, 0,   7);
        run(0, 16'd99,   "d99",   0, 9,   9);
        run(0, 16'd100,  "d100",  0, 'hF, 'hF);
        run(0, 16'h80,   "m128",  0, 'hF, 'hF);
        run(0, 16'h9D,   "m99",   1, 9,   9);
        run(2, 16'hFF,   "u255",  0, 'hF, 'hF);
        run(2, 16'd7,    "u7",    0, 'hA, 7);
        run(3, 16'h8,    "w4m8",  1, 'hA, 8);

        repeat (5) @(negedge clock);
        check("hold.dezena", int'(dez[0]), 9);
        check("hold.sinal", int'(sin[0]), 1);

        // restart while busy must be ignored, and a valor change mid-run has no effect
        @(negedge clock);
        valor[0]   = 16'd15;
        iniciar[0] = 1'b1;
        @(negedge clock);
        iniciar[0] = 1'b0;
        repeat (2) @(negedge clock);
        valor[0]   = 16'd99;
        iniciar[0] = 1'b1;
        @(negedge clock);
        iniciar[0] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (conc[0]) pulses++;
        end
        check("ign.pulses", pulses, 1);
        check("ign.sinal", int'(sin[0]), 0);
        check("ign.dezena", int'(dez[0]), 1);
        check("ign.unidade", int'(uni[0]), 5);

        // back-to-back start in the concluido cycle
        @(negedge clock);
        valor[0]   = 16'd42;
        iniciar[0] = 1'b1;
        @(negedge clock);
        iniciar[0] = 1'b0;
        wait_done(0, n);
        check("b2b.first", n, 9);
        valor[0]   = 16'd57;
        iniciar[0] = 1'b1;
        @(negedge clock);
        iniciar[0] = 1'b0;
        check("b2b.accept", int'(ocup[0]), 1);
        wait_done(0, n);
        check("b2b.lat", n, 9);
        check("b2b.dezena", int'(dez[0]), 5);
        check("b2b.unidade", int'(uni[0]), 7);

        // reset mid-conversion aborts without a concluido pulse
        @(negedge clock);
        valor[0]   = 16'd42;
        iniciar[0] = 1'b1;
        @(negedge clock);
        iniciar[0] = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort.ocupado", int'(ocup[0]), 0);
        check("abort.sinal", int'(sin[0]), 0);
        check("abort.dezena", int'(dez[0]), 'hA);
        check("abort.unidade", int'(uni[0]), 'hA);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (conc[0]) pulses++;
        end
        check("abort.pulses", pulses, 0);
        check("abort.hold", int'(uni[0]), 'hA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
